// File: rtl/rf_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_NREQ   = 2;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin grant: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW:0] idx;
    logic        found;

    // Scan from ptr, wrapping past N-1, and take the first request seen.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile writeback arbiter: round-robin share of the single write port, one
// registered output stage, and a per-register pending scoreboard for RAW stalls.
// Optional feature macro: WB_FWD_EN adds fwd_hit/fwd_data so consumers can take
// the staged write by forwarding instead of stalling on it.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NREQ       = RF_NREQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    input  logic                       sb_set,
    input  logic [ADDR_WIDTH-1:0]      sb_set_addr,
    input  logic [ADDR_WIDTH-1:0]      sb_qaddr,
    output logic                       sb_busy
`ifdef WB_FWD_EN
    ,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data
`endif
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 2**ADDR_WIDTH;

    logic [PW-1:0]         ptr;
    logic [NREQ-1:0]       gnt;
    logic                  xfer;
    logic [PW-1:0]         win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NREG-1:0]       pending;
    logic [NREG-1:0]       pending_nxt;
    logic                  staged_hit;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    // The output stage never stalls, so every grant is a transfer; nothing is granted in reset.
    assign req_ready = rst ? '0 : gnt;
    assign xfer      = |(req_valid & req_ready);

    // Mux the winning requester's index, address and data.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx  = PW'(i);
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Advance the round-robin pointer past the requester that just transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
        end
    end

    // Output stage: a write to x0 is accepted but dropped, and the address/data hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer && win_addr != '0) begin
            rf_wen   <= 1'b1;
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // Commit clears the pending bit; a same-cycle issue to that register re-sets it.
    always_comb begin
        pending_nxt = pending;
        if (rf_wen) begin
            pending_nxt[rf_waddr] = 1'b0;
        end
        if (sb_set && sb_set_addr != '0) begin
            pending_nxt[sb_set_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign staged_hit = rf_wen && (rf_waddr == sb_qaddr) && (sb_qaddr != '0);

`ifdef WB_FWD_EN
    assign sb_busy  = pending[sb_qaddr];
    assign fwd_hit  = staged_hit;
    assign fwd_data = rf_wdata;
`else
    assign sb_busy  = pending[sb_qaddr] | staged_hit;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (default build, forwarding disabled).
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [RF_NREQ-1:0]            req_valid = '0;
    logic [RF_NREQ-1:0]            req_ready;
    logic [RF_NREQ*RF_ADDR_W-1:0]  req_addr;
    logic [RF_NREQ*RF_DATA_W-1:0]  req_data;
    logic                          rf_wen;
    logic [RF_ADDR_W-1:0]          rf_waddr;
    logic [RF_DATA_W-1:0]          rf_wdata;
    logic                          sb_set = 1'b0;
    logic [RF_ADDR_W-1:0]          sb_set_addr = '0;
    logic [RF_ADDR_W-1:0]          sb_qaddr = '0;
    logic                          sb_busy;

    wb_req_t alu = '0;
    wb_req_t lsu = '0;

    int n_checks = 0;
    int n_errors = 0;

    assign req_addr = {lsu.addr, alu.addr};
    assign req_data = {lsu.data, alu.data};

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .sb_qaddr    (sb_qaddr),
        .sb_busy     (sb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        // reset state, with requests pending
        req_valid = 2'b11;
        alu = '{addr: 5'd1, data: 32'h1};
        lsu = '{addr: 5'd2, data: 32'h2};
        #12;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_wen", rf_wen, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'h0);
        chk("rst_busy", sb_busy, 1'b0);
        req_valid = 2'b00;
        rst = 1'b0;
        step();

        // single ALU write, one-cycle latency
        alu = '{addr: 5'd5, data: 32'hA5A5A5A5};
        req_valid = 2'b01;
        sb_qaddr = 5'd5;
        #1;
        chk("alu_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("alu_wen", rf_wen, 1'b1);
        chk("alu_waddr", rf_waddr, 5'd5);
        chk("alu_wdata", rf_wdata, 32'hA5A5A5A5);
        chk("alu_staged_busy", sb_busy, 1'b1);
        step();
        chk("alu_wen_drop", rf_wen, 1'b0);
        chk("alu_waddr_hold", rf_waddr, 5'd5);
        chk("alu_busy_after", sb_busy, 1'b0);

        // back to ptr=0, then both requesters contend for 4 cycles
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        step();
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            alu = '{addr: 5'd10, data: 32'h100 + 32'(c)};
            lsu = '{addr: 5'd11, data: 32'h200 + 32'(c)};
            #1;
            chk("rr_ready", req_ready, exp_rdy[c]);
            step();
            chk("rr_wen", rf_wen, 1'b1);
            chk("rr_waddr", rf_waddr, (c % 2 == 0) ? 5'd10 : 5'd11);
            chk("rr_wdata", rf_wdata, (c % 2 == 0) ? 32'h100 + 32'(c) : 32'h200 + 32'(c));
        end
        req_valid = 2'b00;
        step();
        chk("rr_idle_wen", rf_wen, 1'b0);

        // LSU write to x0: accepted, never written, never busy
        lsu = '{addr: 5'd0, data: 32'hFFFFFFFF};
        req_valid = 2'b10;
        sb_qaddr = 5'd0;
        #1;
        chk("x0_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        chk("x0_wen", rf_wen, 1'b0);
        chk("x0_busy", sb_busy, 1'b0);
        sb_set = 1'b1;
        sb_set_addr = 5'd0;
        step();
        sb_set = 1'b0;
        chk("x0_set_busy", sb_busy, 1'b0);

        // scoreboard: issue r7, write r7, busy until commit
        sb_set = 1'b1;
        sb_set_addr = 5'd7;
        sb_qaddr = 5'd7;
        step();
        sb_set = 1'b0;
        chk("sb_pending", sb_busy, 1'b1);
        sb_qaddr = 5'd6;
        #1;
        chk("sb_other", sb_busy, 1'b0);
        sb_qaddr = 5'd7;
        alu = '{addr: 5'd7, data: 32'h77};
        req_valid = 2'b01;
        #1;
        chk("sb_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("sb_staged_wen", rf_wen, 1'b1);
        chk("sb_staged_busy", sb_busy, 1'b1);
        step();
        chk("sb_commit_busy", sb_busy, 1'b0);

        // issue r7 in the same cycle as its commit: set wins
        sb_set = 1'b1;
        step();
        sb_set = 1'b0;
        req_valid = 2'b10;
        lsu = '{addr: 5'd7, data: 32'h7777};
        step();
        req_valid = 2'b00;
        chk("race_staged", rf_waddr, 5'd7);
        sb_set = 1'b1;
        step();
        sb_set = 1'b0;
        chk("race_wen", rf_wen, 1'b0);
        chk("race_busy", sb_busy, 1'b1);

        // reset while a write is staged
        alu = '{addr: 5'd3, data: 32'h42};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("rst2_staged", rf_wen, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst2_wen", rf_wen, 1'b0);
        chk("rst2_waddr", rf_waddr, 5'd0);
        chk("rst2_busy7", sb_busy, 1'b0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst2_ptr", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("rst2_after_wen", rf_wen, 1'b1);
        chk("rst2_after_waddr", rf_waddr, 5'd3);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
